// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive controller.
package ps2_pkg;

   localparam int unsigned DATA_BITS              = 8;
   localparam int unsigned BIT_CNT_W              = $clog2(DATA_BITS);
   localparam int unsigned DEFAULT_FIFO_DEPTH     = 4;
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 20000;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } ps2_state_e;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous scan-code FIFO; head reads as zero while empty.
module ps2_rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a write when a pop frees the slot in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: pin synchronizer, frame FSM and scan-code FIFO.
// Define PS2_RX_TIMEOUT_EN to abort frames whose PS/2 clock stalls.
module ps2_rx_ctrl
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       enable,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       frame_active,
   output logic       overflow,
   output logic       frame_err
);

   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two in 2..16");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   logic [1:0]           clk_sync_q, data_sync_q;
   logic                 clk_prev_q;
   logic                 fall, data_bit;
   ps2_state_e           state_q, state_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic                 push, bad_frame, to_hit;
   logic                 overflow_q, frame_err_q;
   logic                 fifo_full, fifo_empty;
   logic                 err_set, ovf_set;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
         clk_prev_q  <= clk_sync_q[1];
      end
   end

   assign fall     = clk_prev_q & ~clk_sync_q[1];
   assign data_bit = data_sync_q[1];

`ifdef PS2_RX_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] to_cnt_q, to_cnt_d;

   assign to_hit = (state_q != StIdle) && (to_cnt_q == TO_LAST);

   always_comb begin
      to_cnt_d = '0;
      if (enable && state_q != StIdle && !fall && !to_hit) to_cnt_d = to_cnt_q + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) to_cnt_q <= '0;
      else       to_cnt_q <= to_cnt_d;
   end
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      push      = 1'b0;
      bad_frame = 1'b0;
      if (!enable) begin
         state_d = StIdle;
      end else if (fall) begin
         unique case (state_q)
            StIdle: begin
               if (!data_bit) begin
                  state_d   = StData;
                  bit_cnt_d = '0;
               end
            end
            StData: begin
               shift_d   = {data_bit, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) state_d = StParity;
            end
            StParity: begin
               parity_d = data_bit;
               state_d  = StStop;
            end
            StStop: begin
               state_d = StIdle;
               // Odd parity over data plus parity bit, and a high stop bit.
               if (data_bit && ^{shift_q, parity_q}) push = 1'b1;
               else                                  bad_frame = 1'b1;
            end
            default: state_d = StIdle;
         endcase
      end else if (to_hit) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
      end
   end

   assign err_set = bad_frame | (enable & ~fall & to_hit);
   assign ovf_set = push & fifo_full & ~rd_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (ovf_set)      overflow_q <= 1'b1;
         else if (clr_err) overflow_q <= 1'b0;
         if (err_set)      frame_err_q <= 1'b1;
         else if (clr_err) frame_err_q <= 1'b0;
      end
   end

   ps2_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (rd_en),
      .wdata (shift_q),
      .head  (rd_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rd_valid     = ~fifo_empty;
   assign frame_active = (state_q != StIdle);
   assign overflow     = overflow_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Randomised scoreboard bench for ps2_rx_ctrl with directed frame scenarios.
module tb_ps2_rx_ctrl;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TO    = 50;
   localparam int          H     = 6;

   logic       clk = 1'b0;
   logic       reset, ps2_clk, ps2_data, enable, rd_en, clr_err;
   logic [7:0] rd_data;
   logic       rd_valid, frame_active, overflow, frame_err;
   logic       mon_pop, force_rd;

   assign rd_en = mon_pop | force_rd;

   always #5 clk = ~clk;

   ps2_rx_ctrl #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .enable       (enable),
      .rd_en        (rd_en),
      .clr_err      (clr_err),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .frame_active (frame_active),
      .overflow     (overflow),
      .frame_err    (frame_err)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   bit         exp_err = 1'b0;
   bit         exp_ovf = 1'b0;
   bit         reader_on = 1'b0;
   int         pop_asked = 0;
   int         pop_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops whenever the DUT offers a byte and a read is wanted.
   initial begin
      mon_pop = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rd_valid && (reader_on || pop_asked != pop_done)) begin
            if (!reader_on) pop_done++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %0h expected none", rd_data);
            end else begin
               check("fifo_head", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
            end
            mon_pop = 1'b1;
         end else begin
            mon_pop = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic odd_par(input logic [7:0] b);
      return ~^b;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_at_stop);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         tick(H);
         ps2_clk = 1'b0;
         if (pop_at_stop && i == 10) begin
            tick(1);
            pop_asked++;
            tick(H - 1);
         end else begin
            tick(H);
         end
         ps2_clk = 1'b1;
      end
   endtask

   // Reference model: a frame is accepted iff stop=1 and data+parity has odd weight.
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                             input bit pop_at_stop);
      bit ok;
      ok = stp && (^{b, par});
      if (ok) begin
         if (!reader_on && exp_q.size() >= DEPTH && !pop_at_stop) exp_ovf = 1'b1;
         else exp_q.push_back(b);
      end else begin
         exp_err = 1'b1;
      end
      send_bits({stp, par, b, 1'b0}, 11, pop_at_stop);
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, exp_err});
      check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
   endtask

   task automatic do_clr();
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      exp_err = 1'b0;
      exp_ovf = 1'b0;
      tick(1);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      reader_on = 1'b1;
      while ((exp_q.size() != 0 || rd_valid) && n < 200) begin
         tick(1);
         n++;
      end
      check({tag, "_drain_in_time"}, {31'd0, n < 200}, 32'd1);
   endtask

   task automatic pop_one(input string tag);
      int n;
      n = 0;
      pop_asked++;
      while (pop_done != pop_asked && n < 50) begin
         tick(1);
         n++;
      end
      check({tag, "_pop_in_time"}, {31'd0, n < 50}, 32'd1);
      tick(1);
   endtask

   initial begin
      logic [7:0] b;
      int         r;
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      enable   = 1'b1;
      clr_err  = 1'b0;
      force_rd = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(1);
      check("rst_rd_data", {24'd0, rd_data}, 32'd0);
      check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("rst_frame_active", {31'd0, frame_active}, 32'd0);
      check_flags("rst");

      // 0x1C, parity 0: rd_valid exactly one cycle after the stop-edge detect cycle.
      send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 10, 1'b0);
      ps2_data = 1'b1;
      tick(H);
      ps2_clk = 1'b0;
      exp_q.push_back(8'h1C);
      tick(1);
      check("lat_valid_c1", {31'd0, rd_valid}, 32'd0);
      tick(1);
      check("lat_valid_c2", {31'd0, rd_valid}, 32'd0);
      tick(1);
      check("lat_valid_c3", {31'd0, rd_valid}, 32'd1);
      check("lat_rd_data", {24'd0, rd_data}, 32'h1C);
      check_flags("lat");
      tick(H - 3);
      ps2_clk = 1'b1;
      tick(2);
      check("lat_idle", {31'd0, frame_active}, 32'd0);
      wait_drain("lat");
      reader_on = 1'b0;

      // Two frames read back in order.
      send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      tick(2);
      check("two_valid", {31'd0, rd_valid}, 32'd1);
      pop_one("two_a");
      pop_one("two_b");
      check("two_empty_valid", {31'd0, rd_valid}, 32'd0);
      check("two_empty_data", {24'd0, rd_data}, 32'd0);

      // Parity error then clear.
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      tick(2);
      check_flags("parity_err");
      check("parity_no_push", {31'd0, rd_valid}, 32'd0);
      do_clr();
      check_flags("parity_clr");

      // Reads on an empty FIFO are ignored.
      force_rd = 1'b1;
      tick(3);
      force_rd = 1'b0;
      check("empty_rd_valid", {31'd0, rd_valid}, 32'd0);
      send_frame(8'h33, odd_par(8'h33), 1'b1, 1'b0);
      wait_drain("empty_rd");
      reader_on = 1'b0;

      // Overflow, then simultaneous push and pop on a full FIFO.
      for (int i = 1; i <= 5; i++) begin
         b = 8'(i);
         send_frame(b, odd_par(b), 1'b1, 1'b0);
      end
      tick(2);
      check_flags("ovf");
      do_clr();
      check_flags("ovf_clr");
      send_frame(8'h06, odd_par(8'h06), 1'b1, 1'b1);
      tick(2);
      check_flags("full_push_pop");
      wait_drain("ovf");

      // Idle edge with data high is ignored.
      send_bits(11'h7FF, 1, 1'b0);
      tick(2);
      check("idle_high_edge", {31'd0, frame_active}, 32'd0);
      check_flags("idle_high_edge");

      // Stalled PS/2 clock mid-frame.
      send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 4, 1'b0);
      tick(60);
`ifdef PS2_RX_TIMEOUT_EN
      exp_err = 1'b1;
      check("stall_active", {31'd0, frame_active}, 32'd0);
`else
      check("stall_active", {31'd0, frame_active}, 32'd1);
      enable = 1'b0;
      tick(1);
      enable = 1'b1;
`endif
      tick(1);
      check_flags("stall");
      check("stall_fifo_empty", {31'd0, rd_valid}, 32'd0);
      do_clr();

      // Enable dropped after four data bits, then a clean frame.
      send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5, 1'b0);
      enable = 1'b0;
      tick(1);
      check("abort_active", {31'd0, frame_active}, 32'd0);
      check_flags("abort");
      enable = 1'b1;
      tick(2);
      send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
      wait_drain("abort");
      check_flags("abort_next");

      // Reset mid-frame empties the FIFO and raises no error.
      reader_on = 1'b0;
      send_frame(8'h77, odd_par(8'h77), 1'b1, 1'b0);
      send_bits({1'b1, 1'b0, 8'h12, 1'b0}, 6, 1'b0);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      exp_q.delete();
      tick(1);
      check("rst_mid_active", {31'd0, frame_active}, 32'd0);
      check("rst_mid_valid", {31'd0, rd_valid}, 32'd0);
      check_flags("rst_mid");

      // Randomised frames with occasional bad parity/stop and aborts.
      reader_on = 1'b1;
      repeat (24) begin
         b = 8'($urandom);
         r = int'($urandom_range(0, 9));
         if (r == 2) begin
            send_bits({1'b1, odd_par(b), b, 1'b0}, int'($urandom_range(2, 9)), 1'b0);
            enable = 1'b0;
            tick(1);
            check("rnd_abort_active", {31'd0, frame_active}, 32'd0);
            enable = 1'b1;
            tick(1);
         end else begin
            send_frame(b, odd_par(b) ^ (r == 0), (r == 1) ? 1'b0 : 1'b1, 1'b0);
         end
         tick(3);
         check_flags("rnd");
         if ($urandom_range(0, 3) == 0) do_clr();
      end
      wait_drain("final");
      check("final_valid", {31'd0, rd_valid}, 32'd0);
      check("final_data", {24'd0, rd_data}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_rx_ctrl.md
PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, scan-code FIFO entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 20000, clk cycles allowed between PS/2 clock falling edges within a frame.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ps2_clk  in  1  raw PS2_CLK pin, asynchronous.
REQ-006 ps2_data  in  1  raw PS2_DATA pin, asynchronous.
REQ-007 enable  in  1  receive enable; low forces the FSM to IDLE.
REQ-008 rd_en  in  1  pop FIFO head.
REQ-009 clr_err  in  1  clear sticky error flags.
REQ-010 rd_data  out  8  FIFO head scan code; 0 when empty.
REQ-011 rd_valid  out  1  FIFO non-empty.
REQ-012 frame_active  out  1  FSM not in IDLE.
REQ-013 overflow  out  1  sticky; byte dropped on full FIFO.
REQ-014 frame_err  out  1  sticky; parity, stop-bit or timeout error.

Function
REQ-015 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is synced-previous=1 and synced-current=0.
REQ-016 Data SHALL be sampled from synchronized ps2_data in the cycle the falling edge is detected.
REQ-017 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: edge with data=0 -> DATA with bit count 0; edge with data=1 -> stay IDLE, no error.
REQ-019 DATA: each edge shifts the bit in LSB first; after the 8th bit -> PARITY.
REQ-020 PARITY: edge captures the parity bit -> STOP.
REQ-021 STOP: on edge -> IDLE; push byte only if stop=1 and data+parity has an odd count of ones; otherwise no push and frame_err set.
REQ-022 rd_valid SHALL assert in the cycle after the stop-bit edge cycle of an accepted frame.
REQ-023 Push on full FIFO without simultaneous pop SHALL drop the new byte and set overflow; FIFO contents unchanged.
REQ-024 Push and pop in the same cycle on a full FIFO SHALL both succeed; overflow not set.
REQ-025 rd_en while empty SHALL be ignored; no pointer change.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-027 enable low: FSM to IDLE next cycle, partial frame discarded without error; FIFO retained, reads still served.
REQ-028 clr_err clears overflow and frame_err; a new error in the same cycle wins and the flag stays set.

Reset
REQ-029 reset SHALL put the FSM in IDLE, empty the FIFO, set bit count and timeout counter to 0, load synchronizer flops with 1, and drive rd_data=0, rd_valid=0, frame_active=0, overflow=0, frame_err=0.
REQ-030 reset mid-frame SHALL discard the partial byte; no push and no error result.

Configuration
REQ-031 Macro PS2_RX_TIMEOUT_EN defined: outside IDLE, a counter clears on each edge and increments otherwise; reaching TIMEOUT_CYCLES-1 forces IDLE, discards the partial byte and sets frame_err.
REQ-032 Macro PS2_RX_TIMEOUT_EN undefined: no counter logic; the FSM leaves non-IDLE states only by edges, enable low or reset.

Structure
REQ-033 Package ps2_pkg SHALL hold the FSM state enum, DATA_BITS=8 and default FIFO_DEPTH/TIMEOUT_CYCLES constants.
REQ-034 Sub-module ps2_rx_fifo (synchronous FIFO with push, pop, full, empty, head) SHALL be instantiated once; synchronizer and FSM stay in ps2_rx_ctrl.

Verification
REQ-035 Frame 0x1C, parity 0, stop 1 -> rd_valid=1 one cycle after the stop edge, rd_data=0x1C, frame_err=0.
REQ-036 Frames 0xF0 (parity 1) then 0x1C, then rd_en twice -> rd_data 0xF0 then 0x1C, then rd_valid=0 and rd_data=0.
REQ-037 Frame 0x1C with parity 1 -> no push, frame_err=1; clr_err pulse -> frame_err=0.
REQ-038 Five valid frames 0x01..0x05 with no reads -> overflow=1; FIFO pops 0x01..0x04; push+pop in the same cycle on a full FIFO -> overflow unchanged.
REQ-039 PS2_RX_TIMEOUT_EN, TIMEOUT_CYCLES=50: start bit plus 3 data edges, then ps2_clk held high 60 cycles -> frame_active=0, frame_err=1, FIFO empty.
REQ-040 enable dropped after 4 data bits -> frame_active=0 next cycle, frame_err=0; next full frame 0x5A received correctly.
